// File: rtl/fifo_sync_pkg.sv
// Shared types and width helpers for the single-clock level-reporting FIFO.
package fifo_sync_pkg;

  // Binary pointer width for a FIFO of the given depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Status bundle, laid out for direct use in a downstream register map.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sync_memory.sv
// Storage array for fifo_sync_level: synchronous write, combinational read.
// Contents are deliberately not reset.
module fifo_sync_memory #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port: one word per accepted push.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_level.sv
// Single-clock FIFO with arbitrary depth, fill level, almost flags, sticky
// overflow/underflow and synchronous flush.
// Define FIFO_SYNC_LEVEL_FWFT_EN for first-word-fall-through; the default
// build uses a registered read with one cycle of latency.
module fifo_sync_level
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned DEPTH              = 16,
  parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          write_enable,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          read_enable,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic                          read_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  // Reject illegal configurations at elaboration.
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_level: DEPTH must be at least 2");
  end
  if (ALMOST_FULL_LEVEL > DEPTH || ALMOST_EMPTY_LEVEL >= DEPTH) begin : g_bad_threshold
    $error("fifo_sync_level: almost-full/almost-empty threshold out of range");
  end

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_mem_rd_data;
  fifo_status_t          w_status;

  // Status decode from the registered level plus the sticky error bits.
  always_comb begin
    w_status              = '0;
    w_status.full         = (r_level == LW'(DEPTH));
    w_status.empty        = (r_level == '0);
    w_status.almost_full  = (r_level >= LW'(ALMOST_FULL_LEVEL));
    w_status.almost_empty = (r_level <= LW'(ALMOST_EMPTY_LEVEL));
    w_status.overflow     = r_overflow;
    w_status.underflow    = r_underflow;
  end

  // Flush wins over both requests; acceptance uses pre-edge full/empty.
  assign w_wr_acc = write_enable & ~w_status.full  & ~flush;
  assign w_rd_acc = read_enable  & ~w_status.empty & ~flush;

  fifo_sync_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (write_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd_data)
  );

  // Pointers advance on accepted accesses and wrap at DEPTH-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
    end
  end

  // Fill level: net change of accepted push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
    end else if (flush) begin
      r_level <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enable && w_status.full) begin
        r_overflow <= 1'b1;
      end
      if (read_enable && w_status.empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_SYNC_LEVEL_FWFT_EN
  // Head word is presented directly; a read pops it.
  assign read_data  = w_mem_rd_data;
  assign read_valid = ~w_status.empty;
`else
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;

  // Registered read: capture the head word on an accepted pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_read_data <= w_mem_rd_data;
      end
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
`endif

  assign full         = w_status.full;
  assign empty        = w_status.empty;
  assign almost_full  = w_status.almost_full;
  assign almost_empty = w_status.almost_empty;
  assign overflow     = w_status.overflow;
  assign underflow    = w_status.underflow;
  assign level        = r_level;

endmodule

// File: tb/tb_fifo_sync_level.sv
// Bench for fifo_sync_level: a DEPTH=16 and a DEPTH=5 instance, each compared
// against a queue-based reference model after every clock edge.
module tb_fifo_sync_level;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       a_we, a_re, a_fl, b_we, b_re, b_fl;
  logic [7:0] a_wd, b_wd;
  logic [7:0] a_rd, b_rd;
  logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic       b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0] a_lvl;
  logic [2:0] b_lvl;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bq_t        qa, qb;
  int         depth [2] = '{16, 5};
  bit         m_ovf [2];
  bit         m_unf [2];
  bit         m_rv  [2];
  logic [7:0] m_rd  [2];

  always #5 clk = ~clk;

  fifo_sync_level #(.DATA_WIDTH(8), .DEPTH(16)) u_a (
    .clk(clk), .reset(reset), .flush(a_fl), .write_enable(a_we), .write_data(a_wd),
    .read_enable(a_re), .read_data(a_rd), .read_valid(a_rv), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .level(a_lvl),
    .overflow(a_ovf), .underflow(a_unf)
  );

  fifo_sync_level #(.DATA_WIDTH(8), .DEPTH(5)) u_b (
    .clk(clk), .reset(reset), .flush(b_fl), .write_enable(b_we), .write_data(b_wd),
    .read_enable(b_re), .read_data(b_rd), .read_valid(b_rv), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .level(b_lvl),
    .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL dut%0d %s observed=0x%0h expected=0x%0h", d, tag, obs, exp);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin
      m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_rv[i] = 1'b0; m_rd[i] = 8'h00;
    end
  endtask

  // One clock edge of FIFO behaviour in queue terms.
  task automatic model_edge(input int d, input bit we, input logic [7:0] wd, input bit re, input bit fl);
    bq_t q;
    bit  was_full, was_empty;
    if (d == 0) q = qa; else q = qb;
    was_full  = (q.size() == depth[d]);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_ovf[d] = 1'b0;
      m_unf[d] = 1'b0;
      m_rv[d]  = 1'b0;
    end else begin
      if (we && was_full)  m_ovf[d] = 1'b1;
      if (re && was_empty) m_unf[d] = 1'b1;
      m_rv[d] = 1'b0;
      if (re && !was_empty) begin
        m_rd[d] = q.pop_front();
        m_rv[d] = 1'b1;
      end
      if (we && !was_full) q.push_back(wd);
    end
    if (d == 0) qa = q; else qb = q;
  endtask

  task automatic check_dut(input int d);
    bq_t        q;
    int         sz, dep;
    logic [7:0] rd;
    logic       rv, full, empty, af, ae, ovf, unf;
    logic [4:0] lvl;
    if (d == 0) begin
      q = qa; rd = a_rd; rv = a_rv; full = a_full; empty = a_empty; af = a_af;
      ae = a_ae; ovf = a_ovf; unf = a_unf; lvl = a_lvl;
    end else begin
      q = qb; rd = b_rd; rv = b_rv; full = b_full; empty = b_empty; af = b_af;
      ae = b_ae; ovf = b_ovf; unf = b_unf; lvl = 5'(b_lvl);
    end
    sz  = q.size();
    dep = depth[d];
    chk(d, "level",        32'(lvl),   32'(sz));
    chk(d, "full",         32'(full),  32'(sz == dep));
    chk(d, "empty",        32'(empty), 32'(sz == 0));
    chk(d, "almost_full",  32'(af),    32'(sz >= dep - 2));
    chk(d, "almost_empty", 32'(ae),    32'(sz <= 2));
    chk(d, "overflow",     32'(ovf),   32'(m_ovf[d]));
    chk(d, "underflow",    32'(unf),   32'(m_unf[d]));
`ifdef FIFO_SYNC_LEVEL_FWFT_EN
    chk(d, "read_valid",   32'(rv),    32'(sz != 0));
    if (sz != 0) chk(d, "read_data", 32'(rd), 32'(q[0]));
`else
    chk(d, "read_valid",   32'(rv),    32'(m_rv[d]));
    chk(d, "read_data",    32'(rd),    32'(m_rd[d]));
`endif
  endtask

  // Drive one cycle on the selected instance (the other idles), then check it.
  task automatic step(input int d, input bit we, input logic [7:0] wd, input bit re, input bit fl);
    a_we = (d == 0) && we; a_wd = wd; a_re = (d == 0) && re; a_fl = (d == 0) && fl;
    b_we = (d == 1) && we; b_wd = wd; b_re = (d == 1) && re; b_fl = (d == 1) && fl;
    @(posedge clk);
    model_edge(0, a_we, a_wd, a_re, a_fl);
    model_edge(1, b_we, b_wd, b_re, b_fl);
    #1;
    check_dut(d);
  endtask

  initial begin
    int bias;
    reset = 1'b0;
    a_we = 0; a_re = 0; a_fl = 0; a_wd = 0;
    b_we = 0; b_re = 0; b_fl = 0; b_wd = 0;
    model_reset();
    #2;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    reset = 1'b1;

    // Fill 0x00..0x0F, then one write too many
    for (int i = 0; i < 16; i++) step(0, 1'b1, 8'(i), 1'b0, 1'b0);
    step(0, 1'b1, 8'hFF, 1'b0, 1'b0);
    // Drain in order, then one read too many
    for (int i = 0; i < 16; i++) step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read/write at level 8, then at full
    for (int i = 0; i < 8; i++)  step(0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)  step(0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);

    // Drain to level 6 with overflow still set, flush with write asserted
    for (int i = 0; i < 9; i++) step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(0, 1'b1, 8'hEE, 1'b0, 1'b1);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Write into an empty FIFO, then pop it
    step(0, 1'b1, 8'hA5, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0);
    // Write and read together on an empty FIFO
    step(0, 1'b1, 8'h5A, 1'b1, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Randomised traffic with alternating fill/drain bias
    for (int i = 0; i < 400; i++) begin
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      step(0, $urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) >= bias,
           $urandom_range(0, 63) == 0);
    end

    // Depth 5: pointer wrap across three fill/drain rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, 1'b1, 8'(8'h10 * r + i), 1'b0, 1'b0);
      if (r == 1) step(1, 1'b1, 8'hCC, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      bias = ((i / 12) % 2 == 0) ? 70 : 30;
      step(1, $urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) >= bias,
           $urandom_range(0, 63) == 0);
    end

    // Asynchronous reset in the middle of a write burst
    step(0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    a_we = 1'b1; a_wd = 8'hBF;
    @(posedge clk);
    model_edge(0, 1'b1, 8'hBF, 1'b0, 1'b0);
    model_edge(1, 1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    a_we = 1'b0;
    reset = 1'b1;
    step(0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
